// File: rtl/i2c_master_byte_engine.sv
// ---------------------------------------------------------------------------
// i2c_master_byte_engine
// Bit-level I2C master. One byte command per valid/ready handshake:
// optional (repeated) START, 8 data bits MSB first, ACK slot, optional STOP.
// Drives open-drain enables for SCL/SDA; the pad tristate lives outside.
//
// Optional feature macro: I2C_CLK_STRETCH_EN
//   defined   : quarter counter freezes while SCL is released but still low
//               (slave clock stretching)
//   undefined : scl_i ignored, timing strictly CLK_DIV per quarter phase
//
// Parameters
//   CLK_DIV  sys_clk_i cycles per SCL quarter phase (>= 2)
// Ports
//   sys_clk_i, sys_rst_i         clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake (ready only when idle)
//   cmd_start/stop/read/ack/data command fields, latched on accept
//   rsp_valid                    one-cycle completion pulse
//   rsp_data / rsp_nack / rsp_err response fields, valid with rsp_valid
//   bus_busy                     START issued, no STOP yet
//   scl_oe / sda_oe              1 = pull pad low, 0 = release
//   scl_i / sda_i                pad levels
// ---------------------------------------------------------------------------
module i2c_master_byte_engine #(
  parameter int CLK_DIV = 250
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       bus_busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t      r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]  r_phase;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;   // write: byte being sent (MSB at [7]); read: bits shifted in
  logic        r_stop;
  logic        r_read;
  logic        r_ack;

  logic        w_freeze;
  logic        w_q_last;
  logic        w_tick;

  // Pad enables {scl_oe, sda_oe} for a given state/phase.
  function automatic logic [1:0] f_pads(input state_t st, input logic [1:0] ph,
                                        input logic dbit, input logic rd,
                                        input logic ack, input logic busy);
    logic [1:0] v;
    v = 2'b00;
    case (st)
      S_START: begin
        case (ph)
          2'd0:    v = {busy, 1'b0};  // held bus: keep SCL low for repeated START
          2'd1:    v = 2'b00;
          2'd2:    v = 2'b01;         // SDA falls while SCL high
          default: v = 2'b11;
        endcase
      end
      S_BIT:   v = {(ph == 2'd0) || (ph == 2'd3), rd ? 1'b0 : ~dbit};
      S_ACK:   v = {(ph == 2'd0) || (ph == 2'd3), rd ? ack : 1'b0};
      S_STOP: begin
        case (ph)
          2'd0:    v = 2'b11;
          2'd1:    v = 2'b01;
          default: v = 2'b00;         // SDA rises while SCL high
        endcase
      end
      default: v = {busy, 1'b0};      // idle: park SCL low only while owning the bus
    endcase
    return v;
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  // A released SCL that still reads low means a slave is stretching the clock.
  assign w_freeze = (r_state != S_IDLE) && !scl_oe && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_freeze     = 1'b0;
`endif

  assign w_q_last = (r_qcnt == Q_LAST);
  assign w_tick   = (r_state != S_IDLE) && w_q_last && !w_freeze;

  // Command FSM, quarter-phase timing, pad drive and response registers.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_phase   <= 2'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_stop    <= 1'b0;
      r_read    <= 1'b0;
      r_ack     <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_nack  <= 1'b0;
      rsp_err   <= 1'b0;
      bus_busy  <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            rsp_err  <= 1'b0;
            rsp_nack <= 1'b0;
            r_stop   <= cmd_stop;
            r_read   <= cmd_read;
            r_ack    <= cmd_ack;
            r_shift  <= cmd_data;
            r_qcnt   <= '0;
            r_phase  <= 2'd0;
            r_bitcnt <= 3'd0;
            if (cmd_start) begin
              r_state          <= S_START;
              cmd_ready        <= 1'b0;
              {scl_oe, sda_oe} <= f_pads(S_START, 2'd0, 1'b0, cmd_read, cmd_ack, bus_busy);
            end else if (bus_busy) begin
              r_state          <= S_BIT;
              cmd_ready        <= 1'b0;
              {scl_oe, sda_oe} <= f_pads(S_BIT, 2'd0, cmd_data[7], cmd_read, cmd_ack, bus_busy);
            end else begin
              // Data without owning the bus: reject, no bus activity.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (!w_freeze) begin
            r_qcnt <= w_q_last ? '0 : r_qcnt + QW'(1);
          end
          if (w_tick) begin
            r_phase          <= r_phase + 2'd1;
            {scl_oe, sda_oe} <= f_pads(r_state, r_phase + 2'd1, r_shift[7], r_read, r_ack, bus_busy);
            case (r_state)
              S_START: begin
                if (r_phase == 2'd3) begin
                  bus_busy         <= 1'b1;
                  r_state          <= S_BIT;
                  {scl_oe, sda_oe} <= f_pads(S_BIT, 2'd0, r_shift[7], r_read, r_ack, 1'b1);
                end
              end
              S_BIT: begin
                if (r_read && (r_phase == 2'd1)) begin
                  r_shift <= {r_shift[6:0], sda_i};
                end
                if (r_phase == 2'd3) begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (!r_read) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                  end
                  if (r_bitcnt == 3'd7) begin
                    r_state          <= S_ACK;
                    {scl_oe, sda_oe} <= f_pads(S_ACK, 2'd0, 1'b0, r_read, r_ack, bus_busy);
                  end else begin
                    // Next bit is the one below the current MSB.
                    {scl_oe, sda_oe} <= f_pads(S_BIT, 2'd0, r_shift[6], r_read, r_ack, bus_busy);
                  end
                end
              end
              S_ACK: begin
                if (!r_read && (r_phase == 2'd1)) begin
                  rsp_nack <= sda_i;
                end
                if (r_phase == 2'd3) begin
                  if (r_stop) begin
                    r_state          <= S_STOP;
                    {scl_oe, sda_oe} <= f_pads(S_STOP, 2'd0, 1'b0, r_read, r_ack, bus_busy);
                  end else begin
                    r_state          <= S_IDLE;
                    cmd_ready        <= 1'b1;
                    rsp_valid        <= 1'b1;
                    {scl_oe, sda_oe} <= f_pads(S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                    if (r_read) begin
                      rsp_data <= r_shift;
                    end
                  end
                end
              end
              S_STOP: begin
                if (r_phase == 2'd3) begin
                  bus_busy         <= 1'b0;
                  r_state          <= S_IDLE;
                  cmd_ready        <= 1'b1;
                  rsp_valid        <= 1'b1;
                  {scl_oe, sda_oe} <= 2'b00;
                  if (r_read) begin
                    rsp_data <= r_shift;
                  end
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_byte_engine
// Directed stimulus with a response scoreboard: each issued command pushes
// its expected response; a monitor pops and compares on every rsp_valid.
// Open-drain pads with pull-ups and a small slave model (ACK, read data,
// clock stretching, START/STOP detection, bit capture on SCL rise).
// ---------------------------------------------------------------------------
module tb_i2c_master_byte_engine;

  localparam int CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 20;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
  logic       cmd_read = 1'b0, cmd_ack = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_busy, scl_oe, sda_oe;
  logic [7:0] rsp_data;
  logic       scl_i, sda_i;

  // slave model state
  logic       slave_hold = 1'b0, slave_read = 1'b0, slave_present = 1'b1;
  logic [7:0] slave_tx = 8'h00;
  logic       slave_quiet = 1'b0, start_flag = 1'b0;
  logic [3:0] pos = 4'd0;
  logic [8:0] cap = 9'h000;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         n_start = 0, n_stop = 0;
  logic [2:0] bidx;
  logic       slave_sda_low;

  int cyc = 0;
  int n_cmp = 0, n_fail = 0;

  typedef struct {
    int         lat;
    int         acc;
    logic [7:0] data;
    logic       nack;
    logic       err;
    logic       chk_data;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
    .cmd_ack(cmd_ack), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .rsp_err(rsp_err), .bus_busy(bus_busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
  );

  // open-drain pads with pull-ups
  assign bidx          = 3'd7 - pos[2:0];
  assign slave_sda_low = !slave_quiet &&
                         (slave_read ? ((pos < 4'd8) && !slave_tx[bidx])
                                     : ((pos == 4'd8) && slave_present));
  assign scl_i = ~(scl_oe | slave_hold);
  assign sda_i = ~(sda_oe | slave_sda_low);

  // slave bus watcher: START/STOP detect, bit position, capture on SCL rise
  always @(negedge clk) begin
    prev_scl <= scl_i;
    prev_sda <= sda_i;
    if (prev_scl && scl_i && prev_sda && !sda_i) begin
      n_start     <= n_start + 1;
      start_flag  <= 1'b1;
      slave_quiet <= 1'b0;
    end
    if (prev_scl && scl_i && !prev_sda && sda_i) n_stop <= n_stop + 1;
    if (!prev_scl && scl_i) begin
      cap[pos] <= sda_i;
      if (slave_read && (pos == 4'd8) && sda_i) slave_quiet <= 1'b1;
    end
    if (prev_scl && !scl_i) begin
      if (start_flag) pos <= 4'd0;
      else            pos <= (pos == 4'd8) ? 4'd0 : pos + 4'd1;
      start_flag <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual=rsp_valid required=no response");
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
          chk({e.name, "_nack"}, {31'd0, rsp_nack}, {31'd0, e.nack});
          if (e.chk_data) chk({e.name, "_data"}, {24'd0, rsp_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic send(input logic st, input logic sp, input logic rd, input logic ak,
                      input logic [7:0] d, input int lat, input logic [7:0] ed,
                      input logic en, input logic ee, input logic ecd, input string nm);
    exp_t e;
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk({nm, "_ready_timeout"}, {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_ack = ak; cmd_data = d;
    e.lat = lat; e.acc = cyc + 1; e.data = ed; e.nack = en; e.err = ee; e.chk_data = ecd; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_rsp_timeout"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    int         s_start, s_stop;
    logic [7:0] v;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_nack",  {31'd0, rsp_nack},  32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    chk("rst_bus_busy",  {31'd0, bus_busy},  32'd0);
    chk("rst_scl_oe",    {31'd0, scl_oe},    32'd0);
    chk("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
    rst = 1'b0;

    // data command with no bus owned: rejected on the cycle after accept
    send(1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 0, 8'h00, 1'b0, 1'b1, 1'b0, "illegal");
    chk("illegal_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("illegal_sda_oe", {31'd0, sda_oe}, 32'd0);
    wait_done("illegal");
    chk("illegal_busy", {31'd0, bus_busy}, 32'd0);

    // START + write 0xA0, no STOP, slave ACKs
    slave_present = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 160, 8'h00, 1'b0, 1'b0, 1'b0, "wrA0");
    wait_done("wrA0");
    for (int i = 0; i < 8; i++) v[7-i] = cap[i];
    chk("wrA0_sda_bits", {24'd0, v}, 32'h0000_00A0);
    chk("wrA0_busy",   {31'd0, bus_busy}, 32'd1);
    chk("wrA0_scl_oe", {31'd0, scl_oe},   32'd1);
    chk("wrA0_sda_oe", {31'd0, sda_oe},   32'd0);

    // read 0x5A with NACK and STOP
    slave_read = 1'b1;
    slave_tx   = 8'h5A;
    s_stop     = n_stop;
    send(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 160, 8'h5A, 1'b0, 1'b0, 1'b1, "rd5A");
    wait_done("rd5A");
    chk("rd5A_ack_slot_released", {31'd0, cap[8]}, 32'd1);
    chk("rd5A_stop_seen", 32'(n_stop), 32'(s_stop + 1));
    chk("rd5A_busy",   {31'd0, bus_busy}, 32'd0);
    chk("rd5A_scl_oe", {31'd0, scl_oe},   32'd0);
    chk("rd5A_sda_oe", {31'd0, sda_oe},   32'd0);
    slave_read = 1'b0;

    // hold the bus, then repeated START + write 0x33 + STOP with no slave
    send(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 160, 8'h00, 1'b0, 1'b0, 1'b0, "wr11");
    wait_done("wr11");
    slave_present = 1'b0;
    s_start = n_start;
    s_stop  = n_stop;
    send(1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 176, 8'h00, 1'b1, 1'b0, 1'b0, "rs_wr33");
    chk("rs_p0_scl_low", {31'd0, scl_oe}, 32'd1);
    chk("rs_p0_sda_rel", {31'd0, sda_oe}, 32'd0);
    repeat (8) @(negedge clk);
    chk("rs_p2_sda_low", {31'd0, sda_oe}, 32'd1);
    chk("rs_p2_scl_rel", {31'd0, scl_oe}, 32'd0);
    wait_done("rs_wr33");
    chk("rs_start_seen", 32'(n_start), 32'(s_start + 1));
    chk("rs_stop_seen",  32'(n_stop),  32'(s_stop + 1));
    chk("rs_busy",       {31'd0, bus_busy}, 32'd0);

    // clock stretching: slave holds SCL low for 20 cycles in BIT p1
    slave_present = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 160, 8'h00, 1'b0, 1'b0, 1'b0, "wr55");
    wait_done("wr55");
    slave_present = 1'b0;
    send(1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 144 + STRETCH_EXTRA, 8'h00, 1'b1, 1'b0, 1'b0, "stretch66");
    repeat (4) @(posedge clk);
    #1 slave_hold = 1'b1;
    repeat (20) @(posedge clk);
    #1 slave_hold = 1'b0;
    wait_done("stretch66");
    chk("stretch_busy", {31'd0, bus_busy}, 32'd1);

    // reset in the middle of a BIT phase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("midbit_scl_oe", {31'd0, scl_oe},   32'd1);
    chk("midbit_sda_oe", {31'd0, sda_oe},   32'd1);
    chk("midbit_ready",  {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_scl_oe", {31'd0, scl_oe},    32'd0);
    chk("abort_sda_oe", {31'd0, sda_oe},    32'd0);
    chk("abort_ready",  {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy",   {31'd0, bus_busy},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("post_abort_ready",  {31'd0, cmd_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
